// File: rtl/serial_byte_receiver_pkg.sv
// ---------------------------------------------------------------------------
// serial_byte_receiver_pkg
// Shared types and constants for the serial byte receiver.
//   rx_state_e : receiver FSM states (IDLE, SHIFT, PARITY)
//   MSB_FIRST / LSB_FIRST : values of Shift_Direction_In. They match the
//   universal shift register's shift-left / shift-right operation codes, so
//   the same control bit can drive both ends of a loopback path.
// ---------------------------------------------------------------------------
package serial_byte_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rx_state_e;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_byte_receiver_out_buf.sv
// ---------------------------------------------------------------------------
// serial_byte_receiver_out_buf
// Single-entry valid/ready holding register for assembled words, with
// sticky overrun detection.
//
// Ports:
//   Clk_In           : clock, rising edge
//   Reset_In         : asynchronous active-high reset
//   push_vld         : a completed word is offered this edge
//   push_data        : the completed word
//   push_perr        : parity result belonging to push_data
//   Byte_Ready_In    : consumer accepts the held word
//   Overrun_Clear_In : clears the sticky overrun flag
//   Byte_Data_Out    : held word
//   Byte_Valid_Out   : held word not yet consumed
//   Parity_Error_Out : parity result held with Byte_Data_Out
//   Overrun_Out      : sticky, a completed word was dropped
// ---------------------------------------------------------------------------
module serial_byte_receiver_out_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  push_vld,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_perr,
    input  logic                  Byte_Ready_In,
    input  logic                  Overrun_Clear_In,
    output logic [DATA_WIDTH-1:0] Byte_Data_Out,
    output logic                  Byte_Valid_Out,
    output logic                  Parity_Error_Out,
    output logic                  Overrun_Out
);

    logic xfer;
    logic can_load;
    logic drop;

    always_comb begin
        xfer     = Byte_Valid_Out & Byte_Ready_In;
        // The slot is free if it is empty or being emptied on this same edge.
        can_load = ~Byte_Valid_Out | Byte_Ready_In;
        drop     = push_vld & ~can_load;
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            Byte_Data_Out    <= '0;
            Byte_Valid_Out   <= 1'b0;
            Parity_Error_Out <= 1'b0;
            Overrun_Out      <= 1'b0;
        end else begin
            if (push_vld && can_load) begin
                Byte_Data_Out    <= push_data;
                Parity_Error_Out <= push_perr;
                Byte_Valid_Out   <= 1'b1;
            end else if (xfer) begin
                Byte_Valid_Out   <= 1'b0;
            end

            // A new overrun beats a simultaneous clear.
            if (drop) begin
                Overrun_Out <= 1'b1;
            end else if (Overrun_Clear_In) begin
                Overrun_Out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_byte_receiver.sv
// ---------------------------------------------------------------------------
// serial_byte_receiver
// Deserializes the universal shift register's serial output back into
// parallel words. MSB-first streams come from the USR's left-side output
// (shift-left), LSB-first streams from its right-side output (shift-right).
//
// Optional feature: define SERIAL_BYTE_RECEIVER_PARITY_CHECK_EN to append an
// even-parity bit to every frame and report its check on Parity_Error_Out.
// Without it, frames are DATA_WIDTH bits and Parity_Error_Out is always 0.
//
// Ports:
//   Clk_In             : clock, all state on the rising edge
//   Reset_In           : asynchronous active-high reset
//   Enable_In          : qualifies every serial bit
//   Frame_Start_In     : marks the first bit of a frame (honoured in IDLE)
//   Shift_Direction_In : 0 = MSB-first, 1 = LSB-first, latched at frame start
//   Serial_Data_In     : serial bit stream
//   Byte_Data_Out      : assembled word
//   Byte_Valid_Out     : Byte_Data_Out holds an unconsumed word
//   Byte_Ready_In      : consumer accepts the word
//   Busy_Out           : frame in progress
//   Overrun_Out        : sticky, a completed word was dropped
//   Overrun_Clear_In   : clears Overrun_Out
//   Parity_Error_Out   : parity result for the word on Byte_Data_Out
// ---------------------------------------------------------------------------
module serial_byte_receiver
    import serial_byte_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Frame_Start_In,
    input  logic                  Shift_Direction_In,
    input  logic                  Serial_Data_In,
    output logic [DATA_WIDTH-1:0] Byte_Data_Out,
    output logic                  Byte_Valid_Out,
    input  logic                  Byte_Ready_In,
    output logic                  Busy_Out,
    output logic                  Overrun_Out,
    input  logic                  Overrun_Clear_In,
    output logic                  Parity_Error_Out
);

    localparam logic [CNT_WIDTH-1:0] LAST_DATA_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);

    rx_state_e             state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] sr_q;
    logic                  dir_q;

    logic                  start;
    logic                  accept;
    logic                  dir_now;
    logic                  last_data_bit;
    logic [DATA_WIDTH-1:0] sr_next;
    logic                  complete;
    logic [DATA_WIDTH-1:0] word;
    logic                  perr;

    always_comb begin
        start   = Enable_In & Frame_Start_In & (state_q == IDLE);
        accept  = start | (Enable_In & (state_q != IDLE));
        // The first bit of a frame must use the live direction input, since
        // the latched copy is only written on that same edge.
        dir_now = (state_q == IDLE) ? Shift_Direction_In : dir_q;
        if (dir_now == MSB_FIRST) begin
            sr_next = {sr_q[DATA_WIDTH-2:0], Serial_Data_In};
        end else begin
            sr_next = {Serial_Data_In, sr_q[DATA_WIDTH-1:1]};
        end
        // cnt_q counts bits already taken, so DATA_WIDTH-1 means the incoming
        // bit is the final data bit.
        last_data_bit = (state_q == SHIFT) & (cnt_q == LAST_DATA_CNT);
    end

`ifdef SERIAL_BYTE_RECEIVER_PARITY_CHECK_EN
    // The parity bit is not shifted in: the data word is already complete in
    // sr_q, and the check folds the incoming parity bit into its XOR.
    always_comb begin
        complete = Enable_In & (state_q == PARITY);
        word     = sr_q;
        perr     = (^sr_q) ^ Serial_Data_In;
    end
`else
    always_comb begin
        complete = Enable_In & last_data_bit;
        word     = sr_next;
        perr     = 1'b0;
    end
`endif

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dir_q   <= MSB_FIRST;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    state_q <= SHIFT;
                    cnt_q   <= CNT_ONE;
                    dir_q   <= Shift_Direction_In;
                    sr_q    <= sr_next;
                end
                SHIFT: begin
                    sr_q <= sr_next;
                    if (last_data_bit) begin
`ifdef SERIAL_BYTE_RECEIVER_PARITY_CHECK_EN
                        state_q <= PARITY;
                        cnt_q   <= cnt_q + CNT_ONE;
`else
                        state_q <= IDLE;
                        cnt_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PARITY: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign Busy_Out = (state_q != IDLE);

    serial_byte_receiver_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .Clk_In           (Clk_In),
        .Reset_In         (Reset_In),
        .push_vld         (complete),
        .push_data        (word),
        .push_perr        (perr),
        .Byte_Ready_In    (Byte_Ready_In),
        .Overrun_Clear_In (Overrun_Clear_In),
        .Byte_Data_Out    (Byte_Data_Out),
        .Byte_Valid_Out   (Byte_Valid_Out),
        .Parity_Error_Out (Parity_Error_Out),
        .Overrun_Out      (Overrun_Out)
    );

endmodule

// File: tb/tb_serial_byte_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_byte_receiver
// Directed and randomized frames against a frame-level reference model.
// Build with SERIAL_BYTE_RECEIVER_PARITY_CHECK_EN defined to cover parity.
// ---------------------------------------------------------------------------
module tb_serial_byte_receiver;

    localparam int DW = 8;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_CHECK_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic          Clk_In = 1'b0;
    logic          Reset_In;
    logic          Enable_In;
    logic          Frame_Start_In;
    logic          Shift_Direction_In;
    logic          Serial_Data_In;
    logic [DW-1:0] Byte_Data_Out;
    logic          Byte_Valid_Out;
    logic          Byte_Ready_In;
    logic          Busy_Out;
    logic          Overrun_Out;
    logic          Overrun_Clear_In;
    logic          Parity_Error_Out;

    serial_byte_receiver #(.DATA_WIDTH(DW)) dut (
        .Clk_In             (Clk_In),
        .Reset_In           (Reset_In),
        .Enable_In          (Enable_In),
        .Frame_Start_In     (Frame_Start_In),
        .Shift_Direction_In (Shift_Direction_In),
        .Serial_Data_In     (Serial_Data_In),
        .Byte_Data_Out      (Byte_Data_Out),
        .Byte_Valid_Out     (Byte_Valid_Out),
        .Byte_Ready_In      (Byte_Ready_In),
        .Busy_Out           (Busy_Out),
        .Overrun_Out        (Overrun_Out),
        .Overrun_Clear_In   (Overrun_Clear_In),
        .Parity_Error_Out   (Parity_Error_Out)
    );

    always #5 Clk_In = ~Clk_In;

    int vectors     = 0;
    int miscompares = 0;

    // Frame-level reference model.
    bit          m_busy;
    int          m_cnt;
    bit          m_bits [FL];
    bit          m_dir;
    bit          m_valid;
    logic [DW-1:0] m_data;
    bit          m_perr;
    bit          m_ovr;

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_cnt   = 0;
        m_dir   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_perr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit fs, input bit dir, input bit b,
                              input bit rdy, input bit clr);
        bit            complete;
        bit            ovr_set;
        logic [DW-1:0] w;
        bit            pe;
        complete = 1'b0;
        ovr_set  = 1'b0;
        w        = '0;
        pe       = 1'b0;
        if (en && (m_busy || fs)) begin
            if (!m_busy) begin
                m_busy = 1'b1;
                m_dir  = dir;
                m_cnt  = 0;
            end
            m_bits[m_cnt] = b;
            m_cnt++;
            if (m_cnt == FL) begin
                complete = 1'b1;
                m_busy   = 1'b0;
                for (int i = 0; i < DW; i++) begin
                    if (m_dir == 1'b0) w[DW-1-i] = m_bits[i];
                    else               w[i]      = m_bits[i];
                    pe ^= m_bits[i];
                end
`ifdef SERIAL_BYTE_RECEIVER_PARITY_CHECK_EN
                pe ^= m_bits[FL-1];
`else
                pe = 1'b0;
`endif
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data  = w;
                m_perr  = pe;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (ovr_set)  m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk(32'(Byte_Valid_Out),   32'(m_valid), {tag, ".valid"});
        chk(32'(Byte_Data_Out),    32'(m_data),  {tag, ".data"});
        chk(32'(Busy_Out),         32'(m_busy),  {tag, ".busy"});
        chk(32'(Overrun_Out),      32'(m_ovr),   {tag, ".ovr"});
        chk(32'(Parity_Error_Out), 32'(m_perr),  {tag, ".perr"});
    endtask

    task automatic step(input bit en, input bit fs, input bit dir, input bit b,
                        input bit rdy, input bit clr, input string tag);
        Enable_In          = en;
        Frame_Start_In     = fs;
        Shift_Direction_In = dir;
        Serial_Data_In     = b;
        Byte_Ready_In      = rdy;
        Overrun_Clear_In   = clr;
        @(posedge Clk_In);
        #1;
        model_edge(en, fs, dir, b, rdy, clr);
        check_outputs(tag);
    endtask

    // stall: 0 = none, 1 = one idle cycle before every bit after the first,
    // 2 = random 0..2 idle cycles before every bit.
    task automatic send_word(input logic [DW-1:0] w, input bit dir, input int stall,
                             input bit rdy_body, input bit rdy_last, input bit par_flip,
                             input string tag);
        bit bits [DW+1];
        int ns;
        for (int i = 0; i < DW; i++) bits[i] = dir ? w[i] : w[DW-1-i];
        bits[DW] = (^w) ^ par_flip;
        for (int i = 0; i < FL; i++) begin
            if (stall == 0)      ns = 0;
            else if (stall == 1) ns = (i == 0) ? 0 : 1;
            else                 ns = $urandom_range(0, 2);
            for (int s = 0; s < ns; s++)
                step(1'b0, rb(), rb(), rb(), rdy_body, 1'b0, tag);
            step(1'b1, (i == 0) ? 1'b1 : rb(), (i == 0) ? dir : rb(), bits[i],
                 (i == FL - 1) ? rdy_last : rdy_body, 1'b0, tag);
        end
    endtask

    initial begin
        Reset_In           = 1'b1;
        Enable_In          = 1'b0;
        Frame_Start_In     = 1'b0;
        Shift_Direction_In = 1'b0;
        Serial_Data_In     = 1'b0;
        Byte_Ready_In      = 1'b0;
        Overrun_Clear_In   = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk_In);
        #1;
        check_outputs("reset");
        Reset_In = 1'b0;

        // MSB-first 1,0,1,0,0,1,0,1 -> A5
        send_word(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0, "a5_msb");
        chk(32'(Byte_Data_Out), 32'hA5, "a5_msb.const");
        chk(32'(Byte_Valid_Out), 32'h1, "a5_msb.vconst");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap");

        // LSB-first: 1,0,1,0,0,1,0,1 -> A5 and 0,1,1,1,1,0,0,0 -> 1E
        send_word(8'hA5, 1'b1, 0, 1'b1, 1'b0, 1'b0, "a5_lsb");
        chk(32'(Byte_Data_Out), 32'hA5, "a5_lsb.const");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");
        send_word(8'h1E, 1'b1, 0, 1'b1, 1'b0, 1'b0, "1e_lsb");
        chk(32'(Byte_Data_Out), 32'h1E, "1e_lsb.const");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");

        // Enable toggling every cycle: 15 edges for 8 bits
        send_word(8'h3C, 1'b0, 1, 1'b1, 1'b0, 1'b0, "3c_stall");
        chk(32'(Byte_Data_Out), 32'h3C, "3c_stall.const");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");

        // Overrun: second word dropped, first retained
        send_word(8'h11, 1'b0, 0, 1'b0, 1'b0, 1'b0, "ovr_a");
        send_word(8'h22, 1'b0, 0, 1'b0, 1'b0, 1'b0, "ovr_b");
        chk(32'(Byte_Data_Out), 32'h11, "ovr.keep_old");
        chk(32'(Overrun_Out), 32'h1, "ovr.set");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_clr");
        chk(32'(Overrun_Out), 32'h0, "ovr.cleared");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");

        // Ready at the second completion edge: new word replaces old
        send_word(8'h11, 1'b0, 0, 1'b0, 1'b0, 1'b0, "rdy_a");
        send_word(8'h22, 1'b0, 0, 1'b0, 1'b1, 1'b0, "rdy_b");
        chk(32'(Byte_Data_Out), 32'h22, "rdy.new_word");
        chk(32'(Overrun_Out), 32'h0, "rdy.no_ovr");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");

`ifdef SERIAL_BYTE_RECEIVER_PARITY_CHECK_EN
        send_word(8'h07, 1'b0, 0, 1'b1, 1'b0, 1'b0, "par_ok");
        chk(32'(Parity_Error_Out), 32'h0, "par_ok.const");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");
        send_word(8'h07, 1'b0, 0, 1'b1, 1'b0, 1'b1, "par_bad");
        chk(32'(Parity_Error_Out), 32'h1, "par_bad.const");
        chk(32'(Byte_Data_Out), 32'h07, "par_bad.data");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");
`endif

        // Asynchronous reset mid-frame with a word held
        send_word(8'h5A, 1'b0, 0, 1'b0, 1'b0, 1'b0, "pre_rst");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "partial");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "partial");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "partial");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "partial");
        Enable_In = 1'b0;
        #2;
        Reset_In = 1'b1;
        #1;
        model_reset();
        chk(32'(Byte_Data_Out), 32'h0, "async_rst.data");
        chk(32'(Byte_Valid_Out), 32'h0, "async_rst.valid");
        chk(32'(Busy_Out), 32'h0, "async_rst.busy");
        chk(32'(Overrun_Out), 32'h0, "async_rst.ovr");
        chk(32'(Parity_Error_Out), 32'h0, "async_rst.perr");
        #2;
        Reset_In = 1'b0;
        send_word(8'hFF, 1'b0, 0, 1'b0, 1'b0, 1'b0, "post_rst");
        chk(32'(Byte_Data_Out), 32'hFF, "post_rst.const");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");

        // Randomized frames, stalls, handshakes and clears
        for (int f = 0; f < 60; f++) begin
            send_word(DW'($urandom), rb(), 2, rb(), rb(), rb(), "rand");
            repeat ($urandom_range(0, 2))
                step(1'b0, rb(), rb(), rb(), rb(), rb(), "rand_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
